// File: rtl/mul_seq32.sv
// Sequential 32x32 shift-and-add multiplier: one 33-bit add per cycle, 64-bit product in 32 steps.
// Optional signed operands are enabled by defining MUL_SIGNED_EN (adds the i_is_signed port).
module mul_seq32 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
`ifdef MUL_SIGNED_EN
  input  logic        i_is_signed,
`endif
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_p
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      r_state;
  logic [31:0] r_mcand;
  logic [64:0] r_acc;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [63:0] r_p;

  logic [31:0] w_a_op;
  logic [31:0] w_b_op;
  logic [32:0] w_sum;
  logic [64:0] w_acc_nxt;
  logic [63:0] w_p_nxt;

  // r_acc[64] is always zero here, so it doubles as the zero-extension of hi.
  assign w_sum     = r_acc[0] ? (r_acc[64:32] + {1'b0, r_mcand}) : r_acc[64:32];
  assign w_acc_nxt = {1'b0, w_sum, r_acc[31:1]};

`ifdef MUL_SIGNED_EN
  logic r_neg;
  logic w_neg_nxt;

  // Magnitudes are taken as 32-bit unsigned, so 0x80000000 maps to itself.
  assign w_a_op    = (i_is_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
  assign w_b_op    = (i_is_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
  assign w_neg_nxt = i_is_signed & (i_a[31] ^ i_b[31]);
  assign w_p_nxt   = r_neg ? (64'd0 - w_acc_nxt[63:0]) : w_acc_nxt[63:0];
`else
  assign w_a_op  = i_a;
  assign w_b_op  = i_b;
  assign w_p_nxt = w_acc_nxt[63:0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
`ifdef MUL_SIGNED_EN
      r_neg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_mcand <= w_a_op;
            r_acc   <= {33'd0, w_b_op};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
`ifdef MUL_SIGNED_EN
            r_neg   <= w_neg_nxt;
`endif
          end
        end
        StRun: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_p     <= w_p_nxt;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_p    = r_p;

endmodule

// File: tb/tb_mul_seq32.sv
// Self-checking bench for mul_seq32: randomized operands against an arithmetic reference model.
// Signed scenarios run only when MUL_SIGNED_EN is defined.
module tb_mul_seq32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sgn = 1'b0;
  logic        busy;
  logic        done;
  logic [63:0] p;

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] last_p = '0;

  always #5 clk = ~clk;

  mul_seq32 u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_a        (a),
    .i_b        (b),
`ifdef MUL_SIGNED_EN
    .i_is_signed(sgn),
`endif
    .o_busy     (busy),
    .o_done     (done),
    .o_p        (p)
  );

  // Low 64 bits of the product of the (sign- or zero-) extended operands.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = s ? {{32{x[31]}}, x} : {32'd0, x};
    ye = s ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  // Drive a one-cycle start; returns on the negedge after the accepting edge.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    sgn = s;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    sgn = 1'($urandom);
  endtask

  // Latency counted in negedges from the negedge that drove start; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++;
    if (p !== 64'd0) $display("FAIL reset_p: got %h want 0", p); else n_pass++;
    rst = 1'b0;
    last_p = '0;
  endtask

  task automatic test_basic;
    int lat;
    start_op(32'd3, 32'd5, 1'b0);
    n_total++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
    n_total++;
    if (p !== last_p) $display("FAIL basic_p_hold: got %h want %h", p, last_p); else n_pass++;
    wait_done(lat);
    n_total++;
    if (lat != 33) $display("FAIL basic_latency: got %0d want 33", lat); else n_pass++;
    n_total++;
    if (p !== 64'h0000_0000_0000_000F) $display("FAIL basic_p: got %h want f", p);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_after_done: got done=%b busy=%b want 0 0", done, busy);
    else n_pass++;
    last_p = 64'h0000_0000_0000_000F;
  endtask

  task automatic test_corners;
    logic [31:0] ca [4] = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'hFFFF_FFFF};
    logic [31:0] cb [4] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0};
    logic [63:0] ce [4] = '{64'hFFFF_FFFE_0000_0001, 64'h0, 64'h0000_0000_FFFF_FFFF, 64'h0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(ca[i], cb[i], 1'b0);
      wait_done(lat);
      n_total++;
      if (p !== ce[i]) $display("FAIL corner_%0d: got %h want %h", i, p, ce[i]);
      else n_pass++;
      last_p = ce[i];
    end
  endtask

  task automatic test_random;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] exp;
    int lat;
    for (int i = 0; i < 12; i++) begin
      x = $urandom;
      y = $urandom;
      exp = ref_mul(x, y, 1'b0);
      start_op(x, y, 1'b0);
      n_total++;
      if (p !== last_p) $display("FAIL rand_hold_%0d: got %h want %h", i, p, last_p);
      else n_pass++;
      wait_done(lat);
      n_total++;
      if (lat != 33 || p !== exp)
        $display("FAIL rand_%0d: got p=%h lat=%0d want p=%h lat=33", i, p, lat, exp);
      else n_pass++;
      last_p = exp;
    end
  endtask

  task automatic test_restart_ignored;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] exp;
    logic [63:0] got;
    int ndone;
    x = $urandom;
    y = $urandom;
    exp = ref_mul(x, y, 1'b0);
    got = '0;
    ndone = 0;
    start_op(x, y, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    a = 32'd7;
    b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        got = p;
      end
    end
    n_total++;
    if (ndone != 1) $display("FAIL restart_ndone: got %0d want 1", ndone); else n_pass++;
    n_total++;
    if (got !== exp) $display("FAIL restart_p: got %h want %h", got, exp); else n_pass++;
    last_p = exp;
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] exp;
    int ndone;
    int lat;
    start_op($urandom, $urandom, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 64'd0)
      $display("FAIL midrst_state: got busy=%b done=%b p=%h want 0 0 0", busy, done, p);
    else n_pass++;
    ndone = 0;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    n_total++;
    if (ndone != 0) $display("FAIL midrst_quiet: got %0d active cycles want 0", ndone);
    else n_pass++;
    x = $urandom;
    y = $urandom;
    exp = ref_mul(x, y, 1'b0);
    start_op(x, y, 1'b0);
    wait_done(lat);
    n_total++;
    if (lat != 33 || p !== exp)
      $display("FAIL midrst_resume: got p=%h lat=%0d want p=%h lat=33", p, lat, exp);
    else n_pass++;
    last_p = exp;
  endtask

  task automatic test_back_to_back;
    int cnt;
    @(negedge clk);
    start = 1'b1;
    a = 32'd2;
    b = 32'd9;
    sgn = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (done !== 1'b1 && cnt < 100);
    n_total++;
    if (cnt != 33 || p !== 64'd18)
      $display("FAIL b2b_first: got lat=%0d p=%h want 33 12", cnt, p);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (done !== 1'b1 && cnt < 100);
      n_total++;
      if (cnt != 34 || p !== 64'd18)
        $display("FAIL b2b_%0d: got period=%0d p=%h want 34 12", k, cnt, p);
      else n_pass++;
    end
    start = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL b2b_drain: got busy=%b want 0", busy); else n_pass++;
    last_p = 64'd18;
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed;
    logic [31:0] sa [3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] sb [3] = '{32'd5, 32'h8000_0000, 32'h8000_0000};
    logic        ss [3] = '{1'b1, 1'b1, 1'b0};
    logic [63:0] se [3] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h4000_0000_0000_0000,
                            64'h4000_0000_0000_0000};
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [63:0] exp;
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(sa[i], sb[i], ss[i]);
      wait_done(lat);
      n_total++;
      if (p !== se[i]) $display("FAIL signed_fixed_%0d: got %h want %h", i, p, se[i]);
      else n_pass++;
    end
    for (int i = 0; i < 12; i++) begin
      x = $urandom;
      y = $urandom;
      s = 1'($urandom);
      exp = ref_mul(x, y, s);
      start_op(x, y, s);
      wait_done(lat);
      n_total++;
      if (p !== exp) $display("FAIL signed_rand_%0d: got %h want %h (s=%b)", i, p, exp, s);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_corners;
    test_random;
    test_restart_ignored;
    test_reset_mid_run;
    test_back_to_back;
`ifdef MUL_SIGNED_EN
    test_signed;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
